// File: rtl/c17_eval_arbiter.sv
// c17_eval_arbiter: round-robin arbiter that shares one external c17 core
// between two requesters. The granted vector is registered onto the core
// inputs, the core is allowed SETTLE_CYC cycles to settle (multicycle path),
// and the captured core outputs are returned with the requester ID over a
// valid/ready response channel.
module c17_eval_arbiter #(
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 4
) (
    input  logic       tau2015_clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [4:0] req0_vec,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [4:0] req1_vec,
    output logic       req1_ready,
    output logic [4:0] dp_in,
    input  logic [1:0] dp_out,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [1:0] rsp_data,
    input  logic       rsp_ready
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        RESP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic             prio;
    logic [CNT_W-1:0] cnt;
    logic             grant_any;
    logic             grant_id;
    logic             accept;

    // Grant selection: a lone requester wins, contention goes to prio.
    // Ready is gated by rst_n so it drops immediately on async reset.
    always_comb begin
        grant_any  = req0_valid | req1_valid;
        grant_id   = (req0_valid && req1_valid) ? prio : req1_valid;
        accept     = rst_n && (state == IDLE) && grant_any;
        req0_ready = accept && !grant_id;
        req1_ready = accept && grant_id;
    end

    // State register.
    always_ff @(posedge tau2015_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept -> settle countdown -> hold response.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = DRIVE;
            DRIVE:   if (cnt == '0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: core input register, settle counter, response capture.
    always_ff @(posedge tau2015_clk or negedge rst_n) begin
        if (!rst_n) begin
            prio      <= 1'b0;
            cnt       <= '0;
            dp_in     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dp_in  <= grant_id ? req1_vec : req0_vec;
                        rsp_id <= grant_id;
                        prio   <= ~grant_id;
                        cnt    <= CNT_LOAD;
                    end
                end
                DRIVE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rsp_data  <= dp_out;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_c17_eval_arbiter.sv
// Bench for c17_eval_arbiter: two instances (SETTLE_CYC=1 with an ideal core,
// SETTLE_CYC=4 with a core whose outputs lag its inputs by 3 cycles).
// Stimulus pushes expected responses; a negedge monitor compares.
`timescale 1ns/1ps
module tb_c17_eval_arbiter;

    typedef struct {
        logic        id;
        logic [1:0]  data;
        int unsigned acc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      r0v, r1v, r0r, r1r, rspv, rspid, rrdy;
    logic [1:0][4:0] r0vec, r1vec, dpi;
    logic [1:0][1:0] dpo, rspd;
    logic [1:0]      d1 = '0, d2 = '0, d3 = '0;

    int unsigned     total = 0;
    int unsigned     bad   = 0;
    int unsigned     cyc   = 0;

    exp_t            q0[$];
    exp_t            q1[$];
    logic [1:0]      m_prio, m_busy, prev_v, hold_id;
    logic [1:0][4:0] m_dp;
    logic [1:0][1:0] hold_d;

    // Clock.
    always #5 clk = ~clk;

    // Edge counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] c17(input logic [4:0] v);
        logic n10, n11, n16, n19;
        n10 = ~(v[0] & v[2]);
        n11 = ~(v[2] & v[3]);
        n16 = ~(v[1] & n11);
        n19 = ~(n11 & v[4]);
        return {~(n16 & n19), ~(n10 & n16)};
    endfunction

    function automatic int unsigned settle_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    // Core models: ideal for instance 0, 3-cycle lagging for instance 1.
    assign dpo[0] = c17(dpi[0]);
    assign dpo[1] = d3;
    always @(posedge clk) begin
        d1 <= c17(dpi[1]);
        d2 <= d1;
        d3 <= d2;
    end

    c17_eval_arbiter #(.SETTLE_CYC(1), .CNT_W(4)) u_dut_s1 (
        .tau2015_clk(clk), .rst_n(rst_n),
        .req0_valid(r0v[0]), .req0_vec(r0vec[0]), .req0_ready(r0r[0]),
        .req1_valid(r1v[0]), .req1_vec(r1vec[0]), .req1_ready(r1r[0]),
        .dp_in(dpi[0]), .dp_out(dpo[0]),
        .rsp_valid(rspv[0]), .rsp_id(rspid[0]), .rsp_data(rspd[0]), .rsp_ready(rrdy[0])
    );

    c17_eval_arbiter #(.SETTLE_CYC(4), .CNT_W(4)) u_dut_s4 (
        .tau2015_clk(clk), .rst_n(rst_n),
        .req0_valid(r0v[1]), .req0_vec(r0vec[1]), .req0_ready(r0r[1]),
        .req1_valid(r1v[1]), .req1_vec(r1vec[1]), .req1_ready(r1r[1]),
        .dp_in(dpi[1]), .dp_out(dpo[1]),
        .rsp_valid(rspv[1]), .rsp_id(rspid[1]), .rsp_data(rspd[1]), .rsp_ready(rrdy[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int i, input exp_t e);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic pop_exp(input int i, output logic ok, output exp_t e);
        ok = 1'b0;
        e  = '{id: 1'b0, data: 2'b00, acc: 0};
        if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
        if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
    endtask

    task automatic clear_q(input int i);
        if (i == 0) q0.delete();
        else        q1.delete();
    endtask

    // Reference model + scoreboard check for one instance, run each negedge.
    task automatic mon(input int i);
        exp_t       e;
        logic       ok, ev, gid;
        logic [4:0] v;
        if (!rst_n) begin
            check("reset_outputs", 32'({r0r[i], r1r[i], rspv[i], rspid[i], rspd[i], dpi[i]}), 32'd0);
            m_prio[i] = 1'b0;
            m_busy[i] = 1'b0;
            m_dp[i]   = '0;
            prev_v[i] = 1'b0;
            clear_q(i);
            return;
        end
        check("dp_in", 32'(dpi[i]), 32'(m_dp[i]));
        if (m_busy[i]) begin
            check("ready_busy", 32'({r0r[i], r1r[i]}), 32'd0);
        end else begin
            ev  = r0v[i] | r1v[i];
            gid = (r0v[i] && r1v[i]) ? m_prio[i] : r1v[i];
            check("grant", 32'({r0r[i], r1r[i]}), 32'({ev && !gid, ev && gid}));
            if (ev) begin
                v      = gid ? r1vec[i] : r0vec[i];
                e.id   = gid;
                e.data = c17(v);
                e.acc  = cyc + 1;
                push_exp(i, e);
                m_dp[i]   = v;
                m_prio[i] = ~gid;
                m_busy[i] = 1'b1;
            end
        end
        if (rspv[i]) begin
            if (!prev_v[i]) begin
                pop_exp(i, ok, e);
                if (!ok) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    check("rsp_id", 32'(rspid[i]), 32'(e.id));
                    check("rsp_data", 32'(rspd[i]), 32'(e.data));
                    check("rsp_latency", cyc - e.acc, settle_of(i));
                end
                hold_id[i] = rspid[i];
                hold_d[i]  = rspd[i];
            end else begin
                check("rsp_hold", 32'({rspid[i], rspd[i]}), 32'({hold_id[i], hold_d[i]}));
            end
            if (rrdy[i]) m_busy[i] = 1'b0;
        end
        prev_v[i] = rspv[i] && !rrdy[i];
    endtask

    // Monitor process.
    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic wait_accept(input int i, input int r);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (r == 0 ? (r0v[i] && r0r[i]) : (r1v[i] && r1r[i])) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int i);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!m_busy[i] && !rspv[i]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input int i, input int r, input logic [4:0] v);
        @(posedge clk); #2;
        if (r == 0) begin r0v[i] = 1'b1; r0vec[i] = v; end
        else        begin r1v[i] = 1'b1; r1vec[i] = v; end
        wait_accept(i, r);
        @(posedge clk); #2;
        if (r == 0) r0v[i] = 1'b0;
        else        r1v[i] = 1'b0;
        wait_idle(i);
    endtask

    task automatic contend(input int i, input int cycles);
        logic a0, a1;
        int   c0, c1, diff;
        c0 = 0;
        c1 = 0;
        @(posedge clk); #2;
        rrdy[i]  = 1'b1;
        r0v[i]   = 1'b1;
        r1v[i]   = 1'b1;
        r0vec[i] = 5'($urandom_range(0, 31));
        r1vec[i] = 5'($urandom_range(0, 31));
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            a0 = r0v[i] && r0r[i];
            a1 = r1v[i] && r1r[i];
            c0 += int'(a0);
            c1 += int'(a1);
            @(posedge clk); #2;
            if (a0) r0vec[i] = 5'($urandom_range(0, 31));
            if (a1) r1vec[i] = 5'($urandom_range(0, 31));
        end
        r0v[i] = 1'b0;
        r1v[i] = 1'b0;
        diff = (c0 > c1) ? c0 - c1 : c1 - c0;
        check("contend_share", 32'(diff <= 1), 32'd1);
        check("contend_rate", 32'(c0 + c1 >= cycles / int'(settle_of(i) + 2) - 1), 32'd1);
        wait_idle(i);
    endtask

    task automatic backpressure(input int i);
        logic ok;
        @(posedge clk); #2;
        rrdy[i]  = 1'b0;
        r1v[i]   = 1'b1;
        r1vec[i] = 5'($urandom_range(0, 31));
        wait_accept(i, 1);
        @(posedge clk); #2;
        r1v[i] = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rspv[i]) begin ok = 1'b1; break; end
        end
        if (!ok) check("bp_rsp_timeout", 32'd0, 32'd1);
        repeat (5) begin
            @(negedge clk);
            check("bp_valid_held", 32'(rspv[i]), 32'd1);
        end
        @(posedge clk); #2;
        rrdy[i]  = 1'b1;
        r0v[i]   = 1'b1;
        r0vec[i] = 5'($urandom_range(0, 31));
        @(negedge clk);
        @(negedge clk);
        check("bp_reaccept", 32'(r0r[i]), 32'd1);
        @(posedge clk); #2;
        r0v[i] = 1'b0;
        wait_idle(i);
    endtask

    task automatic rand_run(input int i, input int cycles);
        logic a0, a1;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            a0 = r0v[i] && r0r[i];
            a1 = r1v[i] && r1r[i];
            @(posedge clk); #2;
            if (a0) r0v[i] = 1'b0;
            if (a1) r1v[i] = 1'b0;
            if (!r0v[i] && $urandom_range(0, 2) == 0) begin
                r0v[i] = 1'b1;
                r0vec[i] = 5'($urandom_range(0, 31));
            end
            if (!r1v[i] && $urandom_range(0, 2) == 0) begin
                r1v[i] = 1'b1;
                r1vec[i] = 5'($urandom_range(0, 31));
            end
            rrdy[i] = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        a0 = r0v[i] && r0r[i];
        a1 = r1v[i] && r1r[i];
        @(posedge clk); #2;
        r0v[i]  = 1'b0;
        r1v[i]  = 1'b0;
        rrdy[i] = 1'b1;
        wait_idle(i);
    endtask

    // Watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Directed and random stimulus.
    initial begin
        rst_n = 1'b0;
        r0v   = '0;
        r1v   = '0;
        rrdy  = '0;
        r0vec = '0;
        r1vec = '0;

        // Request pending during reset must not be acknowledged.
        r0v   = 2'b11;
        r0vec = {5'h1F, 5'h1F};
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        rrdy  = 2'b11;
        @(negedge clk);
        check("first_idle_ready", 32'(r0r), 32'd3);
        @(posedge clk); #2;
        r0v = '0;
        fork wait_idle(0); wait_idle(1); join

        // Single requests with known vectors.
        fork send(0, 0, 5'h1F); send(1, 0, 5'h1F); join
        fork send(0, 0, 5'h00); send(1, 0, 5'h00); join
        fork send(0, 1, 5'h15); send(1, 1, 5'h0A); join

        fork contend(0, 36); contend(1, 36); join
        fork backpressure(0); backpressure(1); join
        fork rand_run(0, 300); rand_run(1, 300); join

        // Reset two cycles into DRIVE aborts the transaction.
        @(posedge clk); #2;
        r0v[1]   = 1'b1;
        r0vec[1] = 5'h1B;
        wait_accept(1, 0);
        @(posedge clk); #2;
        r0v[1] = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_dp_in", 32'(dpi[1]), 32'd0);
        check("abort_rsp_valid", 32'(rspv[1]), 32'd0);
        r0v[1]   = 1'b1;
        r1v[1]   = 1'b1;
        r0vec[1] = 5'h07;
        r1vec[1] = 5'h18;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_grant", 32'({r0r[1], r1r[1]}), 32'd2);
        @(posedge clk); #2;
        r0v[1] = 1'b0;
        wait_accept(1, 1);
        @(posedge clk); #2;
        r1v[1] = 1'b0;
        fork wait_idle(0); wait_idle(1); join

        repeat (10) @(negedge clk);
        check("queues_empty", 32'(q0.size() + q1.size()), 32'd0);
        check("all_idle", 32'(m_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/c17_eval_arbiter.md
Name: c17_eval_arbiter

Overview:
Round-robin arbiter and sequencer that shares one combinational c17 evaluation core (5 inputs, 2 outputs) between two requesters. It registers the granted input vector onto the core and waits a programmable settle time, treating the core as a multicycle path. It then captures the core outputs and returns them with a requester ID over a valid/ready response channel. The core sits outside this block; the block drives its inputs and samples its outputs.

Parameters:
SETTLE_CYC, 1, cycles from input-register load to output capture; legal range 1..15; 0 is illegal.
CNT_W, 4, settle counter width; must hold SETTLE_CYC-1.

Ports:
tau2015_clk  input  1  clock, all state rising-edge.
rst_n  input  1  asynchronous active-low reset.
req0_valid  input  1  requester 0 has a vector.
req0_vec  input  5  requester 0 vector.
req0_ready  output  1  requester 0 accepted this cycle.
req1_valid  input  1  requester 1 has a vector.
req1_vec  input  5  requester 1 vector.
req1_ready  output  1  requester 1 accepted this cycle.
dp_in  output  5  registered core inputs: [0]=nx1, [1]=nx2, [2]=nx3, [3]=nx6, [4]=nx7.
dp_out  input  2  core outputs: [0]=nx22, [1]=nx23.
rsp_valid  output  1  response available.
rsp_id  output  1  requester that owns the response.
rsp_data  output  2  captured dp_out.
rsp_ready  input  1  response consumer accepts.

Behaviour:
- Reset (async assert, sync-released by the top level):
  - state=IDLE, prio=0, cnt=0.
  - dp_in=0, rsp_valid=0, rsp_id=0, rsp_data=0.
  - req0_ready=0, req1_ready=0.
- FSM states: IDLE, DRIVE, RESP.
- IDLE, grant selection (combinational):
  - If only one reqN_valid is high, grant that requester.
  - If both are high, grant requester prio.
  - reqN_ready=1 only in IDLE and only for the granted N; it is never high in DRIVE or RESP.
- IDLE, handshake at the edge where reqN_valid && reqN_ready:
  - dp_in<=reqN_vec, rsp_id<=N, prio<=~N.
  - cnt<=SETTLE_CYC-1, state<=DRIVE.
- DRIVE:
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: rsp_data<=dp_out, rsp_valid<=1, state<=RESP.
- Latency: rsp_valid rises exactly SETTLE_CYC edges after the accept edge.
- RESP:
  - rsp_valid, rsp_id and rsp_data hold stable while rsp_ready=0.
  - At the edge with rsp_ready=1: rsp_valid<=0, state<=IDLE.
  - A new accept is possible on the following edge at the earliest.
  - Throughput: one transaction per SETTLE_CYC+2 cycles with no backpressure.
- dp_in changes only at accept edges and holds the last vector otherwise (core inputs never glitch during settle).
- Requesters must hold valid and vec until ready; a valid that drops before grant is simply not served, with no error.
- prio updates only on an accept. A lone requester does not starve the other: the next contention goes to the other requester.
- Async reset asserted in DRIVE or RESP aborts the transaction with no response. All outputs return to reset values immediately (combinational ready outputs go to 0 as well).
- rsp_ready while rsp_valid=0 is ignored.

Test Plan:
- Reset then idle: hold rst_n=0 with req0_valid=1 -> req0_ready=0, dp_in=0, rsp_valid=0. Release reset -> req0_ready=1 in the first IDLE cycle.
- Single request, SETTLE_CYC=1, core attached:
  - req0_vec=5'b11111 -> accept at E0, dp_in=5'b11111, rsp_valid=1 after E1, rsp_id=0, rsp_data=2'b01.
  - Repeat with 5'b00000 -> rsp_data=2'b00.
- Contention: both valid every cycle, rsp_ready=1 -> grant order 0,1,0,1 (rsp_id alternates); each requester gets exactly 1 of every 2 responses.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_id and rsp_data constant, both req*_ready=0. Raise rsp_ready -> IDLE next edge, new accept one edge later.
- Settle timing, SETTLE_CYC=4: bench model delays dp_out by 3 cycles -> captured value equals the fully settled result; rsp_valid rises exactly 4 edges after accept.
- Mid-operation reset: assert rst_n=0 two cycles into DRIVE -> rsp_valid never rises, dp_in=0 immediately. After release, prio=0: with both valid, req0 is granted first.
